// File: rtl/risc_imm_packer_if.sv
// Handshake and payload bundle between an immediate-packer producer/consumer and the packer.
// master = environment side (drives requests, accepts packed words), slave = packer.
interface risc_imm_packer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            imm_src;
  logic [DATA_WIDTH-1:0] imm_value;
  logic [DATA_WIDTH-1:0] base_instr;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_err;

  modport master (
    output in_valid, imm_src, imm_value, base_instr, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err
  );

  modport slave (
    input  in_valid, imm_src, imm_value, base_instr, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err
  );
endinterface

// File: rtl/risc_imm_packer.sv
// Scatters an immediate into a RISC-V instruction word (inverse of decode-side extraction),
// flags range/alignment errors and emits address-tagged words through a one-entry output register.
//
// state | meaning
// EMPTY | no packed word held; out_valid=0
// FULL  | packed word held on out_*; out_valid=1
module risc_imm_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        clear,
  risc_imm_packer_if.slave bus,
  output logic [15:0] err_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [DATA_WIDTH-1:0] out_instr_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;
  logic                  out_err_q;
  logic [DATA_WIDTH-1:0] packed_instr;
  logic                  imm_err;
  logic                  out_valid;
  logic                  in_ready;
  logic                  accept;
  logic [DATA_WIDTH-1:0] imm;

  assign imm       = bus.imm_value;
  assign out_valid = (state == FULL);
  assign in_ready  = !clear && (!out_valid || bus.out_ready);
  assign accept    = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_instr = out_instr_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_err   = out_err_q;

  // Error words are still packed with the truncated immediate and forwarded.
  always_comb begin
    packed_instr = bus.base_instr;
    imm_err      = 1'b0;
    case (bus.imm_src)
      2'b00: begin
        packed_instr[31:20] = imm[11:0];
        imm_err = (imm[31:11] != {21{imm[11]}});
      end
      2'b01: begin
        packed_instr[31:25] = imm[11:5];
        packed_instr[11:7]  = imm[4:0];
        imm_err = (imm[31:11] != {21{imm[11]}});
      end
      2'b10: begin
        packed_instr[31]    = imm[12];
        packed_instr[7]     = imm[11];
        packed_instr[30:25] = imm[10:5];
        packed_instr[11:8]  = imm[4:1];
        imm_err = (imm[31:12] != {20{imm[12]}}) || imm[0];
      end
      default: begin
        packed_instr[31]    = imm[20];
        packed_instr[19:12] = imm[19:12];
        packed_instr[20]    = imm[11];
        packed_instr[30:21] = imm[10:1];
        imm_err = (imm[31:20] != {12{imm[20]}}) || imm[0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear)                         state_nxt = EMPTY;
    else if (accept)                   state_nxt = FULL;
    else if (out_valid && bus.out_ready) state_nxt = EMPTY;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr_cnt    <= BASE;
      err_count   <= 16'd0;
      out_instr_q <= '0;
      out_addr_q  <= BASE;
      out_err_q   <= 1'b0;
    end else if (clear) begin
      addr_cnt  <= BASE;
      err_count <= 16'd0;
    end else if (accept) begin
      out_instr_q <= packed_instr;
      out_addr_q  <= addr_cnt;
      out_err_q   <= imm_err;
      addr_cnt    <= addr_cnt + 1'b1;
      if (imm_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end

endmodule
